f_fetch_unit: RTL and testbench

- F-stage fetch engine of the 5-stage MIPS pipeline; the consumer of the D-stage next-PC value.
- Holds the architectural fetch PC and loads the D-stage NPC whenever the F/D register advances.
- Fetches from instruction memory over a req/gnt/rvalid handshake with one outstanding request.
- Presents instruction, PC and valid to the F/D register, and to D-stage NPC logic as PC_F.

---
 rtl/f_fetch_unit_pkg.sv | 23 ++
 rtl/f_fetch_unit_addr_check.sv | 24 ++
 rtl/f_fetch_unit.sv | 101 ++++++++++
 tb/tb_f_fetch_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/f_fetch_unit_pkg.sv
// Shared constants for the F-stage fetch engine and the D-stage NPC logic.
// Holds the reset and memory-map defaults, the fetch FSM encodings and the NPC op codes.
package f_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
    localparam int unsigned IM_WORDS_DEF = 4096;
    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2
    } f_state_t;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JUMP   = 2'd2,
        NPC_JREG   = 2'd3
    } npc_op_t;

endpackage

// File: rtl/f_fetch_unit_addr_check.sv
// Combinational fetch-address legality test: word alignment plus unsigned range
// check against the instruction memory window.
module f_addr_check #(
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 4096
) (
    input  logic [31:0] pc,
    output logic        exc_adel
);
    localparam logic [32:0] IM_BYTES = 33'(IM_WORDS) << 2;

    logic [31:0] offset;
    logic        misaligned;
    logic        below_base;
    logic        beyond_top;

    assign offset     = pc - IM_BASE;
    assign misaligned = (pc[1:0] != 2'b00);
    assign below_base = (pc < IM_BASE);
    // Widened so a window ending exactly at 2^32 still compares correctly.
    assign beyond_top = ({1'b0, offset} >= IM_BYTES);
    assign exc_adel   = misaligned | below_base | beyond_top;

endmodule

// File: rtl/f_fetch_unit.sv
// F-stage fetch engine: owns the fetch PC, issues one instruction-memory request at a
// time and holds the fetched word for the F/D register until it advances.
module f_fetch_unit
    import f_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
    parameter int unsigned IM_WORDS = IM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_F,
    input  logic [31:0] npc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_gnt,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic [31:0] instr_F,
    output logic [31:0] pc_F,
    output logic        valid_F,
    output logic        exc_adel_F
);
    f_state_t    state_q, state_d;
    logic [31:0] pc_d;
    logic [31:0] instr_d;
    logic        valid_d;
    logic        exc_d;
    logic        addr_exc;

    f_addr_check #(
        .IM_BASE  (IM_BASE),
        .IM_WORDS (IM_WORDS)
    ) u_addr_check (
        .pc       (pc_F),
        .exc_adel (addr_exc)
    );

    assign im_addr = pc_F;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FS_REQ;
            pc_F       <= RESET_PC;
            instr_F    <= NOP_WORD;
            valid_F    <= 1'b0;
            exc_adel_F <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_F       <= pc_d;
            instr_F    <= instr_d;
            valid_F    <= valid_d;
            exc_adel_F <= exc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_F;
        instr_d = instr_F;
        valid_d = valid_F;
        exc_d   = exc_adel_F;
        im_req  = 1'b0;
        case (state_q)
            FS_REQ: begin
                // An illegal PC never reaches memory; it is presented as an excepted nop.
                if (addr_exc) begin
                    state_d = FS_HOLD;
                    valid_d = 1'b1;
                    exc_d   = 1'b1;
                    instr_d = NOP_WORD;
                end else begin
                    im_req = 1'b1;
                    if (im_gnt) begin
                        state_d = FS_WAIT;
                    end
                end
            end
            FS_WAIT: begin
                if (im_rvalid) begin
                    state_d = FS_HOLD;
                    instr_d = im_rdata;
                    valid_d = 1'b1;
                end
            end
            FS_HOLD: begin
                if (valid_F && !stall_F) begin
                    state_d = FS_REQ;
                    pc_d    = npc;
                    valid_d = 1'b0;
                    exc_d   = 1'b0;
                    instr_d = NOP_WORD;
                end
            end
            default: begin
                state_d = FS_REQ;
            end
        endcase
    end

endmodule

// File: tb/tb_f_fetch_unit.sv
// Scoreboard bench for f_fetch_unit: a latency-configurable memory responder serves
// requests, and expected fetches are queued whenever a new npc is driven.
module tb_f_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_F;
    logic [31:0] npc;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_gnt;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic [31:0] instr_F;
    logic [31:0] pc_F;
    logic        valid_F;
    logic        exc_adel_F;

    f_fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .stall_F    (stall_F),
        .npc        (npc),
        .im_req     (im_req),
        .im_addr    (im_addr),
        .im_gnt     (im_gnt),
        .im_rvalid  (im_rvalid),
        .im_rdata   (im_rdata),
        .instr_F    (instr_F),
        .pc_F       (pc_F),
        .valid_F    (valid_F),
        .exc_adel_F (exc_adel_F)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] gnt_q[$];
    int          n_chk = 0;
    int          n_fail = 0;

    int          gnt_lat = 0;
    int          rv_lat = 1;
    bit          spur_req = 1'b0;
    bit          stale_kick = 1'b0;
    bit          pend = 1'b0;
    int          rv_cnt = 0;
    int          req_wait = 0;
    logic [31:0] pend_addr = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
    endfunction

    function automatic logic exp_exc(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a > 32'h0000_6FFC);
    endfunction

    task automatic push_exp(input logic [31:0] a);
        exp_t e;
        e.pc    = a;
        e.exc   = exp_exc(a);
        e.instr = e.exc ? 32'h0 : mem_word(a);
        sb.push_back(e);
    endtask

    // Memory responder: grants after gnt_lat request cycles, returns data rv_lat cycles later.
    initial begin
        im_gnt = 1'b0;
        im_rvalid = 1'b0;
        im_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            im_gnt = 1'b0;
            im_rvalid = 1'b0;
            im_rdata = 32'h0;
            if (!reset && !stale_kick) begin
                chk("single_outstanding", 32'(im_req & pend), 32'h0);
            end
            if (stale_kick) begin
                im_rvalid = 1'b1;
                im_rdata = 32'hDEAD_BEEF;
                pend = 1'b0;
                stale_kick = 1'b0;
            end else if (pend) begin
                rv_cnt--;
                if (rv_cnt <= 0) begin
                    im_rvalid = 1'b1;
                    im_rdata = mem_word(pend_addr);
                    pend = 1'b0;
                end
            end else if (im_req && !reset) begin
                if (spur_req) begin
                    im_rvalid = 1'b1;
                    im_rdata = 32'hBAD0_BAD0;
                    spur_req = 1'b0;
                end
                if (req_wait >= gnt_lat) begin
                    im_gnt = 1'b1;
                    pend = 1'b1;
                    pend_addr = im_addr;
                    rv_cnt = rv_lat;
                    req_wait = 0;
                    gnt_q.push_back(im_addr);
                end else begin
                    req_wait++;
                end
            end
        end
    end

    task automatic fetch_check(input logic [31:0] next_npc, input int stall_n,
                               input int exp_lat, input bit push_next);
        exp_t e;
        int   n;
        n = 0;
        while (!valid_F && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!valid_F) begin
            chk("fetch_timeout", 32'(valid_F), 32'h1);
            return;
        end
        if (exp_lat >= 0) chk("latency", n, exp_lat);
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'(sb.size()), 32'h1);
            return;
        end
        e = sb.pop_front();
        chk("pc_F", pc_F, e.pc);
        chk("instr_F", instr_F, e.instr);
        chk("exc_adel_F", 32'(exc_adel_F), 32'(e.exc));
        if (e.exc) begin
            chk("no_mem_req", 32'(gnt_q.size()), 32'h0);
        end else if (gnt_q.size() != 1) begin
            chk("req_count", 32'(gnt_q.size()), 32'h1);
        end else begin
            chk("im_addr", gnt_q.pop_front(), e.pc);
        end
        gnt_q.delete();
        if (stall_n > 0) begin
            stall_F = 1'b1;
            for (int i = 0; i < stall_n; i++) begin
                @(posedge clk);
                #1;
                chk("stall_pc", pc_F, e.pc);
                chk("stall_instr", instr_F, e.instr);
                chk("stall_valid", 32'(valid_F), 32'h1);
                chk("stall_req", 32'(im_req), 32'h0);
            end
            stall_F = 1'b0;
        end
        npc = next_npc;
        if (push_next) push_exp(next_npc);
        @(posedge clk);
        #1;
        npc = 32'hFFFF_FFF0;
        chk("advance_valid", 32'(valid_F), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        stall_F = 1'b0;
        npc = 32'h0;
        #2;
        chk("rst_pc", pc_F, 32'h0000_3000);
        chk("rst_valid", 32'(valid_F), 32'h0);
        chk("rst_instr", instr_F, 32'h0);
        chk("rst_exc", 32'(exc_adel_F), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        push_exp(32'h0000_3000);

        fetch_check(32'h0000_3004, 0, -1, 1'b1);
        fetch_check(32'h0000_3008, 5, 2, 1'b1);
        fetch_check(32'h0000_3100, 0, 2, 1'b1);   // 0x3008 is the delay slot
        fetch_check(32'h0000_3102, 0, 2, 1'b1);
        fetch_check(32'h0000_2FFC, 0, 1, 1'b1);
        gnt_lat = 3;
        rv_lat = 4;
        spur_req = 1'b1;
        fetch_check(32'h0000_3104, 0, 1, 1'b1);
        fetch_check(32'h0000_3108, 0, 8, 1'b0);
        chk("spur_consumed", 32'(spur_req), 32'h0);

        // Reset while a granted fetch to 0x3108 is in flight.
        gnt_lat = 0;
        rv_lat = 20;
        n = 0;
        while (gnt_q.size() == 0 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("inflight_gnt", 32'(gnt_q.size()), 32'h1);
        #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_pc", pc_F, 32'h0000_3000);
        chk("mid_rst_valid", 32'(valid_F), 32'h0);
        chk("mid_rst_instr", instr_F, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        stale_kick = 1'b1;
        rv_lat = 1;
        gnt_q.delete();
        sb.delete();
        push_exp(32'h0000_3000);

        fetch_check(32'h0000_6FFC, 0, -1, 1'b1);
        fetch_check(32'h0000_7000, 0, 2, 1'b1);
        fetch_check(32'h0000_3000, 0, 1, 1'b1);
        fetch_check(32'h0000_3004, 0, 2, 1'b0);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
